// File: rtl/mult_pkg.sv
// Purpose : shared types, widths and the sign/magnitude to two's-complement helper
//           for the multiplier arbiter and its round-robin picker.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package mult_pkg;

   localparam int OP_W  = 8;   // signed operand width
   localparam int MAG_W = 15;  // datapath product magnitude width
   localparam int RES_W = 16;  // two's-complement product width
   localparam int ID_W  = 3;   // requester id width (up to 8 requesters)

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Widen the magnitude with a zero MSB and negate in the full result width.
   // -128 * -128 gives magnitude 16384, which still fits below the sign bit.
   function automatic logic [RES_W-1:0] to_twos(input logic [MAG_W-1:0] mag,
                                                input logic             neg);
      logic [RES_W-1:0] ext;
      ext = {1'b0, mag};
      return neg ? (~ext + 1'b1) : ext;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose : round-robin picker; first set request found searching upward from ptr_i, wrapping.
// Latency : purely combinational.
// Backpr. : none; the caller decides when the grant is consumed.
//
// Ports:
//   req_i  [N-1:0]    request vector
//   ptr_i  [ID_W-1:0] highest-priority index for this search
//   gnt_o  [N-1:0]    one-hot grant (all zero when no request)
//   idx_o  [ID_W-1:0] encoded grant index (0 when no request)
module rr_arbiter
   import mult_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]    req_i,
   input  logic [ID_W-1:0] ptr_i,
   output logic [N-1:0]    gnt_o,
   output logic [ID_W-1:0] idx_o
);

   int   cand;
   logic found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = 0;
      for (int off = 0; off < N; off++) begin
         cand = (int'(ptr_i) + off) % N;
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = ID_W'(cand);
         end
      end
   end

endmodule

// File: rtl/mult_arbiter.sv
// Purpose : shares one sequential signed multiplier among N_REQ requesters with round-robin
//           grants, converts sign/magnitude results to 16-bit two's complement, tags them by id.
// Latency : acceptance to rsp_valid = bit-length(|a|) + 2 cycles; TIMEOUT + 1 on a stuck datapath.
// Backpr. : one operation in flight; no new grant while a response waits for rsp_ready_i.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_valid_i/req_ready_o       per-requester request handshake (ready is one-hot, IDLE only)
//   req_a_i/req_b_i               packed signed operands, requester i at [8i+7:8i]
//   rsp_valid_o/rsp_ready_i       response handshake
//   rsp_id_o/rsp_data_o/rsp_err_o response id, signed product, timeout flag (data 0 on timeout)
//   mult_start_o/mult_a_o/mult_b_o       drive to the shared datapath
//   mult_product_i/mult_sign_i/mult_done_i result from the shared datapath
module mult_arbiter
   import mult_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 12
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [N_REQ-1:0]      req_valid_i,
   output logic [N_REQ-1:0]      req_ready_o,
   input  logic [OP_W*N_REQ-1:0] req_a_i,
   input  logic [OP_W*N_REQ-1:0] req_b_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [ID_W-1:0]       rsp_id_o,
   output logic [RES_W-1:0]      rsp_data_o,
   output logic                  rsp_err_o,
   output logic                  mult_start_o,
   output logic [OP_W-1:0]       mult_a_o,
   output logic [OP_W-1:0]       mult_b_o,
   input  logic [MAG_W-1:0]      mult_product_i,
   input  logic                  mult_sign_i,
   input  logic                  mult_done_i
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_t           state_q;
   logic [ID_W-1:0]  ptr_q;
   logic [ID_W-1:0]  id_q;
   logic [CNT_W-1:0] cnt_q;
   logic             rsp_valid_q;
   logic [ID_W-1:0]  rsp_id_q;
   logic [RES_W-1:0] rsp_data_q;
   logic             rsp_err_q;
   logic             mult_start_q;
   logic [OP_W-1:0]  mult_a_q;
   logic [OP_W-1:0]  mult_b_q;

   logic [N_REQ-1:0] gnt_oh;
   logic [ID_W-1:0]  gnt_idx;
   logic             accept;
   logic [ID_W-1:0]  ptr_d;
   logic [RES_W-1:0] rsp_data_d;
   logic [OP_W-1:0]  a_sel;
   logic [OP_W-1:0]  b_sel;
   logic             tmo_hit;

   rr_arbiter #(
      .N (N_REQ)
   ) u_rr_arbiter (
      .req_i (req_valid_i),
      .ptr_i (ptr_q),
      .gnt_o (gnt_oh),
      .idx_o (gnt_idx)
   );

   // Grant is only offered while idle, so a response waiting on rsp_ready_i blocks new work.
   assign req_ready_o = (state_q == IDLE) ? gnt_oh : '0;
   assign accept      = |(req_valid_i & req_ready_o);

   // Next search starts just after the winner so every requester is reached within N_REQ grants.
   assign ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

   assign a_sel      = req_a_i[gnt_idx*OP_W +: OP_W];
   assign b_sel      = req_b_i[gnt_idx*OP_W +: OP_W];
   assign rsp_data_d = to_twos(mult_product_i, mult_sign_i);

   // The last permitted WAIT cycle; the counter counts WAIT cycles already spent.
   assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         id_q         <= '0;
         cnt_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_data_q   <= '0;
         rsp_err_q    <= 1'b0;
         mult_start_q <= 1'b0;
         mult_a_q     <= '0;
         mult_b_q     <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  mult_a_q     <= a_sel;
                  mult_b_q     <= b_sel;
                  id_q         <= gnt_idx;
                  ptr_q        <= ptr_d;
                  mult_start_q <= 1'b1;
                  state_q      <= ISSUE;
               end
            end
            ISSUE: begin
               // mult_done_i still reflects the previous operation here, so it is not looked at.
               mult_start_q <= 1'b0;
               cnt_q        <= '0;
               state_q      <= WAIT;
            end
            WAIT: begin
               if (mult_done_i) begin
                  rsp_data_q  <= rsp_data_d;
                  rsp_err_q   <= 1'b0;
                  rsp_id_q    <= id_q;
                  rsp_valid_q <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= RESP;
               end else if (tmo_hit) begin
                  rsp_data_q  <= '0;
                  rsp_err_q   <= 1'b1;
                  rsp_id_q    <= id_q;
                  rsp_valid_q <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_id_o     = rsp_id_q;
   assign rsp_data_o   = rsp_data_q;
   assign rsp_err_o    = rsp_err_q;
   assign mult_start_o = mult_start_q;
   assign mult_a_o     = mult_a_q;
   assign mult_b_o     = mult_b_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: sequential-multiplier stub, per-cycle transaction model, directed ops.
module tb_mult_arbiter;

   localparam int N   = 4;
   localparam int TMO = 12;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_ready;
   logic [8*N-1:0] req_a;
   logic [8*N-1:0] req_b;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [2:0]    rsp_id;
   logic [15:0]   rsp_data;
   logic          rsp_err;
   logic          mult_start;
   logic [7:0]    mult_a;
   logic [7:0]    mult_b;
   logic [14:0]   dp_prod;
   logic          dp_sign;
   logic          mult_done;
   logic          stuck;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int grants_q[$];

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   mult_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_a_i        (req_a),
      .req_b_i        (req_b),
      .rsp_valid_o    (rsp_valid),
      .rsp_ready_i    (rsp_ready),
      .rsp_id_o       (rsp_id),
      .rsp_data_o     (rsp_data),
      .rsp_err_o      (rsp_err),
      .mult_start_o   (mult_start),
      .mult_a_o       (mult_a),
      .mult_b_o       (mult_b),
      .mult_product_i (dp_prod),
      .mult_sign_i    (dp_sign),
      .mult_done_i    (mult_done)
   );

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int bitlen(input int v);
      int k = 0;
      while ((v >> k) != 0) k++;
      return k;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   // Sequential multiplier stub: loads on start, done rises bit-length(|a|) edges later, no reset.
   int dp_cnt = 0;
   always @(posedge clk_i) begin
      if (mult_start) begin
         dp_prod <= 15'(iabs(int'($signed(mult_a))) * iabs(int'($signed(mult_b))));
         dp_sign <= mult_a[7] ^ mult_b[7];
         dp_cnt  <= bitlen(iabs(int'($signed(mult_a))));
      end else if (dp_cnt > 0) begin
         dp_cnt <= dp_cnt - 1;
      end
   end
   initial begin
      dp_prod = '0;
      dp_sign = 1'b0;
   end
   assign mult_done = (dp_cnt == 0) && !stuck;

   // Transaction model: one op in flight, result due a fixed latency after acceptance.
   logic       m_busy = 1'b0;
   int         m_ptr  = 0;
   int         m_e0   = 0;
   int         m_due  = 0;
   int         m_id   = 0;
   logic [7:0] m_a    = '0;
   logic [7:0] m_b    = '0;
   logic [15:0] m_data = '0;
   logic       m_err  = 1'b0;

   always @(negedge clk_i) begin
      logic [N-1:0] er;
      logic         ev;
      int           w;
      int           sa;
      int           sb;
      if (!rst_ni) begin
         m_busy = 1'b0;
         m_ptr  = 0;
         m_a    = '0;
         m_b    = '0;
         chk("rst_req_ready", 32'(req_ready), 32'd0);
         chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
         chk("rst_mult_start", 32'(mult_start), 32'd0);
         chk("rst_mult_a", 32'(mult_a), 32'd0);
         chk("rst_mult_b", 32'(mult_b), 32'd0);
         chk("rst_rsp_data", 32'(rsp_data), 32'd0);
         chk("rst_rsp_id", 32'(rsp_id), 32'd0);
         chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      end else begin
         er = '0;
         w  = -1;
         if (!m_busy) begin
            for (int off = 0; off < N; off++)
               if (w < 0 && req_valid[(m_ptr + off) % N]) w = (m_ptr + off) % N;
         end
         if (w >= 0) er[w] = 1'b1;
         ev = m_busy && (cyc >= m_due);
         chk("m_req_ready", 32'(req_ready), 32'(er));
         chk("m_rsp_valid", 32'(rsp_valid), 32'(ev));
         chk("m_mult_start", 32'(mult_start), 32'(m_busy && (cyc == m_e0)));
         chk("m_mult_a", 32'(mult_a), 32'(m_a));
         chk("m_mult_b", 32'(mult_b), 32'(m_b));
         if (ev) begin
            chk("m_rsp_id", 32'(rsp_id), 32'(m_id));
            chk("m_rsp_data", 32'(rsp_data), 32'(m_data));
            chk("m_rsp_err", 32'(rsp_err), 32'(m_err));
         end
         if (w >= 0) begin
            m_busy = 1'b1;
            m_e0   = cyc + 1;
            m_a    = req_a[w*8 +: 8];
            m_b    = req_b[w*8 +: 8];
            sa     = int'($signed(m_a));
            sb     = int'($signed(m_b));
            m_id   = w;
            m_err  = stuck;
            m_data = stuck ? 16'd0 : 16'(sa * sb);
            m_due  = m_e0 + (stuck ? TMO + 1 : bitlen(iabs(sa)) + 2);
            m_ptr  = (w + 1) % N;
            grants_q.push_back(w);
         end else if (ev && rsp_ready) begin
            m_busy = 1'b0;
         end
      end
   end

   // Issue one op from requester i and check latency/result against hand-computed values.
   task automatic do_op(input int i, input int a, input int b, input int exp_lat,
                        input logic [15:0] exp_data, input logic exp_err,
                        input string nm, output int waited);
      int t0;
      bit ok;
      req_a[i*8 +: 8] = 8'(a);
      req_b[i*8 +: 8] = 8'(b);
      req_valid[i]    = 1'b1;
      waited = 0;
      ok     = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk_i);
         if (req_ready[i]) begin
            ok = 1'b1;
            break;
         end
         waited++;
      end
      chk({nm, "_grant_seen"}, 32'(ok), 32'd1);
      t0 = cyc + 1;
      @(posedge clk_i);
      #1 req_valid[i] = 1'b0;
      if (!ok) return;
      ok = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk_i);
         if (rsp_valid) begin
            ok = 1'b1;
            break;
         end
      end
      chk({nm, "_rsp_seen"}, 32'(ok), 32'd1);
      if (ok) begin
         chk({nm, "_latency"}, 32'(cyc - t0), 32'(exp_lat));
         chk({nm, "_data"}, 32'(rsp_data), 32'(exp_data));
         chk({nm, "_id"}, 32'(rsp_id), 32'(i));
         chk({nm, "_err"}, 32'(rsp_err), 32'(exp_err));
      end
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      int   w;
      bit   ok;
      logic [15:0] held;
      rst_ni    = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      stuck     = 1'b0;
      repeat (2) @(posedge clk_i);
      #2;
      chk("reset_req_ready", 32'(req_ready), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_mult_a", 32'(mult_a), 32'd0);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      // Fairness: all requesters continuously valid, grants must rotate from 0.
      for (int i = 0; i < N; i++) begin
         req_a[i*8 +: 8] = 8'(i + 1);
         req_b[i*8 +: 8] = 8'(10 * (i + 1) - 25);
      end
      req_valid = '1;
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk_i);
         if (grants_q.size() >= 8) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk_i);
      #1 req_valid = '0;
      chk("fair_eight_grants", 32'(ok), 32'd1);
      if (ok)
         for (int k = 0; k < 8; k++) chk("fair_grant_order", 32'(grants_q[k]), 32'(k % 4));
      repeat (15) @(posedge clk_i);
      #1;

      // Single op and corner operands, rsp_ready tied high.
      do_op(0, 3, -5, 4, 16'hFFF1, 1'b0, "single", w);
      do_op(1, -128, -128, 10, 16'h4000, 1'b0, "neg128sq", w);
      do_op(2, 0, -7, 2, 16'h0000, 1'b0, "zero_a", w);
      do_op(3, -1, 127, 3, 16'hFF81, 1'b0, "m1x127", w);
      do_op(0, 127, 127, 9, 16'h3F01, 1'b0, "p127sq", w);

      // Timeout with done stuck low.
      stuck = 1'b1;
      do_op(1, 5, 6, TMO + 1, 16'h0000, 1'b1, "timeout", w);
      stuck = 1'b0;
      do_op(2, 2, -3, 4, 16'hFFFA, 1'b0, "after_tmo", w);

      // Backpressure: response held 5+ cycles, next grant only after RESP exits.
      rsp_ready = 1'b0;
      req_a[8 +: 8]  = 8'd2;
      req_b[8 +: 8]  = 8'd3;
      req_a[16 +: 8] = 8'd4;
      req_b[16 +: 8] = 8'd5;
      req_valid[1]   = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk_i);
         if (req_ready[1]) begin
            ok = 1'b1;
            break;
         end
      end
      chk("bp_grant1", 32'(ok), 32'd1);
      @(posedge clk_i);
      #1 req_valid[1] = 1'b0;
      req_valid[2] = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk_i);
         if (rsp_valid) begin
            ok = 1'b1;
            break;
         end
      end
      chk("bp_rsp_seen", 32'(ok), 32'd1);
      held = 16'd6;
      repeat (5) begin
         @(negedge clk_i);
         chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
         chk("bp_hold_data", 32'(rsp_data), 32'(held));
         chk("bp_hold_id", 32'(rsp_id), 32'd1);
         chk("bp_no_grant", 32'(req_ready), 32'd0);
      end
      @(posedge clk_i);
      #1 rsp_ready = 1'b1;
      @(negedge clk_i);
      chk("bp_last_resp_cycle", 32'(req_ready), 32'd0);
      @(negedge clk_i);
      chk("bp_grant_after_exit", 32'(req_ready), 32'b0100);
      @(posedge clk_i);
      #1 req_valid[2] = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk_i);
         if (rsp_valid) begin
            ok = 1'b1;
            break;
         end
      end
      chk("bp_second_rsp", 32'(ok), 32'd1);
      chk("bp_second_data", 32'(rsp_data), 32'd20);
      @(posedge clk_i);
      #1;

      // Asynchronous reset in the middle of WAIT.
      req_a[16 +: 8] = 8'd100;
      req_b[16 +: 8] = 8'd3;
      req_valid[2]   = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk_i);
         if (req_ready[2]) begin
            ok = 1'b1;
            break;
         end
      end
      chk("rw_grant", 32'(ok), 32'd1);
      @(posedge clk_i);
      #1 req_valid[2] = 1'b0;
      repeat (3) @(posedge clk_i);
      #2 chk("rw_pre_mult_a", 32'(mult_a), 32'd100);
      #1 rst_ni = 1'b0;
      #1;
      chk("rw_async_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rw_async_mult_start", 32'(mult_start), 32'd0);
      chk("rw_async_mult_a", 32'(mult_a), 32'd0);
      chk("rw_async_mult_b", 32'(mult_b), 32'd0);
      chk("rw_async_rsp_data", 32'(rsp_data), 32'd0);
      chk("rw_async_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk_i);
      @(posedge clk_i);
      #2 rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      // Requesters 1 and 3 both valid; a reset pointer must pick 1 first.
      req_a[24 +: 8] = 8'(-2);
      req_b[24 +: 8] = 8'd50;
      req_valid[3]   = 1'b1;
      do_op(1, 7, -9, 5, 16'hFFC1, 1'b0, "post_rst", w);
      chk("post_rst_first_grant_wait", 32'(w), 32'd0);
      do_op(3, -2, 50, 4, 16'hFF9C, 1'b0, "post_rst_r3", w);

      repeat (4) @(posedge clk_i);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
      $fatal(1, "watchdog");
   end

endmodule
